draw_tank: RTL and testbench

DRAW_TANK -- requirements
Module: draw_tank

---
 rtl/draw_tank.sv | 140 ++++++++++++++
 tb/tb_draw_tank.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/draw_tank.sv
// draw_tank: overlays a keyed sprite read from an external synchronous ROM
// onto a video stream. Three-stage pipeline: address generation, ROM wait,
// compositing. Counters and timing ride alongside so that every output lines
// up with the inputs sampled three edges earlier.
module draw_tank #(
   parameter int         XSIZE     = 48,
   parameter int         YSIZE     = 64,
   parameter logic [11:0] KEY_COLOR = 12'h000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   input  logic [10:0] xpos,
   input  logic [10:0] ypos,
   input  logic [11:0] rom_rgb,
   output logic [11:0] pixel_addr,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   // sprite position, frozen for a whole frame
   logic [10:0] r_xpos_l, r_ypos_l;

   // stage 1 / stage 2 pipeline; timing packed as {hsync, vsync, hblnk, vblnk}
   logic        r_inside_1, r_inside_2;
   logic [10:0] r_hcount_1, r_hcount_2, r_vcount_1, r_vcount_2;
   logic [3:0]  r_tim_1, r_tim_2;
   logic [11:0] r_rgb_1, r_rgb_2;

   // 12-bit comparisons so xpos_l+XSIZE never wraps back to column 0
   logic [11:0] w_h12, w_v12, w_xs12, w_ys12, w_xe12, w_ye12;
   logic        w_inside;
   logic [5:0]  w_dx, w_dy;
   logic [11:0] w_rgb_next;

   assign w_h12  = {1'b0, hcount_in};
   assign w_v12  = {1'b0, vcount_in};
   assign w_xs12 = {1'b0, r_xpos_l};
   assign w_ys12 = {1'b0, r_ypos_l};
   assign w_xe12 = w_xs12 + 12'(XSIZE);
   assign w_ye12 = w_ys12 + 12'(YSIZE);
   // only the low six bits of the offsets form the ROM address
   assign w_dx   = hcount_in[5:0] - r_xpos_l[5:0];
   assign w_dy   = vcount_in[5:0] - r_ypos_l[5:0];

   // sprite window test for the current input pixel
   always_comb begin
      w_inside = (w_h12 >= w_xs12) && (w_h12 < w_xe12) &&
                 (w_v12 >= w_ys12) && (w_v12 < w_ye12);
   end

   // compositing: blanking forces black, key colour shows the background
   always_comb begin
      w_rgb_next = r_rgb_2;
      if (r_tim_2[1] || r_tim_2[0])
         w_rgb_next = 12'h000;
      else if (r_inside_2 && (rom_rgb != KEY_COLOR))
         w_rgb_next = rom_rgb;
   end

   // position latch: update only at the first pixel of a frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xpos_l <= '0;
         r_ypos_l <= '0;
      end else if ((hcount_in == 11'd0) && (vcount_in == 11'd0)) begin
         r_xpos_l <= xpos;
         r_ypos_l <= ypos;
      end
   end

   // stage 1: ROM address and first delay of the side-band signals
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixel_addr <= '0;
         r_inside_1 <= 1'b0;
         r_hcount_1 <= '0;
         r_vcount_1 <= '0;
         r_tim_1    <= '0;
         r_rgb_1    <= '0;
      end else begin
         pixel_addr <= w_inside ? {w_dy, w_dx} : 12'h000;
         r_inside_1 <= w_inside;
         r_hcount_1 <= hcount_in;
         r_vcount_1 <= vcount_in;
         r_tim_1    <= {hsync_in, vsync_in, hblnk_in, vblnk_in};
         r_rgb_1    <= rgb_in;
      end
   end

   // stage 2: match the ROM's one-clock read latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inside_2 <= 1'b0;
         r_hcount_2 <= '0;
         r_vcount_2 <= '0;
         r_tim_2    <= '0;
         r_rgb_2    <= '0;
      end else begin
         r_inside_2 <= r_inside_1;
         r_hcount_2 <= r_hcount_1;
         r_vcount_2 <= r_vcount_1;
         r_tim_2    <= r_tim_1;
         r_rgb_2    <= r_rgb_1;
      end
   end

   // stage 3: registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         hcount_out <= r_hcount_2;
         vcount_out <= r_vcount_2;
         hsync_out  <= r_tim_2[3];
         vsync_out  <= r_tim_2[2];
         hblnk_out  <= r_tim_2[1];
         vblnk_out  <= r_tim_2[0];
         rgb_out    <= w_rgb_next;
      end
   end

endmodule

// File: tb/tb_draw_tank.sv
// Bench for draw_tank: directed pixels with hand-computed ROM addresses and
// composited colours; expectations are queued at issue time and checked by an
// independent monitor when the pipeline delivers them.
module tb_draw_tank;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] hcount_in = 11'd2000, vcount_in = 11'd1000;
   logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b1, vblnk_in = 1'b1;
   logic [11:0] rgb_in = '0;
   logic [10:0] xpos = '0, ypos = '0;
   logic [11:0] rom_rgb = '0;
   logic [11:0] pixel_addr, rgb_out;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;

   int tests = 0, fails = 0, cyc = 0;

   typedef struct {
      int          due;
      logic [11:0] addr;
   } addr_exp_t;

   typedef struct {
      int          due;
      logic [10:0] h, v;
      logic [3:0]  tim;
      logic [11:0] rgb;
   } out_exp_t;

   addr_exp_t addr_q[$];
   out_exp_t  out_q[$];

   draw_tank #(.XSIZE(48), .YSIZE(64), .KEY_COLOR(12'h000)) dut (
      .clk(clk), .rst_n(rst_n),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
      .rom_rgb(rom_rgb), .pixel_addr(pixel_addr),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out),
      .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out)
   );

   always #5 clk = ~clk;

   // sprite ROM model: address 0x0C3 holds the key colour, all others addr|0x800
   always @(posedge clk)
      rom_rgb <= (pixel_addr == 12'h0C3) ? 12'h000 : (pixel_addr | 12'h800);

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: after each edge, compare whatever expectations fall due now
   always @(posedge clk) begin
      #1;
      cyc++;
      while (addr_q.size() > 0 && addr_q[0].due == cyc) begin
         addr_exp_t a;
         a = addr_q.pop_front();
         chk("pixel_addr", pixel_addr, a.addr);
      end
      while (out_q.size() > 0 && out_q[0].due == cyc) begin
         out_exp_t o;
         o = out_q.pop_front();
         chk("rgb_out", rgb_out, o.rgb);
         chk("hcount_out", {1'b0, hcount_out}, {1'b0, o.h});
         chk("vcount_out", {1'b0, vcount_out}, {1'b0, o.v});
         chk("timing_out", {8'h00, hsync_out, vsync_out, hblnk_out, vblnk_out}, {8'h00, o.tim});
      end
   end

   // drive one pixel at a negedge; next posedge is stage 1 for it
   task automatic apply(input logic [10:0] h, input logic [10:0] v, input logic [3:0] tim,
                        input logic [11:0] rgb, input logic [10:0] xp, input logic [10:0] yp,
                        input logic [11:0] e_addr, input logic [11:0] e_rgb);
      addr_exp_t a;
      out_exp_t  o;
      hcount_in = h; vcount_in = v;
      {hsync_in, vsync_in, hblnk_in, vblnk_in} = tim;
      rgb_in = rgb; xpos = xp; ypos = yp;
      a.due = cyc + 1; a.addr = e_addr;
      o.due = cyc + 3; o.h = h; o.v = v; o.tim = tim; o.rgb = e_rgb;
      addr_q.push_back(a);
      out_q.push_back(o);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      hcount_in = 11'd2000; vcount_in = 11'd1000;
      {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'b0011;
      rgb_in = '0;
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_all_zero();
      chk("rst pixel_addr", pixel_addr, 12'h000);
      chk("rst rgb_out", rgb_out, 12'h000);
      chk("rst hcount_out", {1'b0, hcount_out}, 12'h000);
      chk("rst vcount_out", {1'b0, vcount_out}, 12'h000);
      chk("rst timing", {8'h00, hsync_out, vsync_out, hblnk_out, vblnk_out}, 12'h000);
   endtask

   initial begin
      #2;
      chk_all_zero();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(4);

      // frame start latches (100,200); blanked so output is black
      apply(11'd0,    11'd0,   4'b0011, 12'h123, 11'd100, 11'd200, 12'h000, 12'h000);
      apply(11'd110,  11'd205, 4'b0000, 12'h456, 11'd100, 11'd200, 12'h14A, 12'h94A);
      apply(11'd99,   11'd205, 4'b0000, 12'h321, 11'd100, 11'd200, 12'h000, 12'h321);
      apply(11'd148,  11'd205, 4'b0000, 12'h654, 11'd100, 11'd200, 12'h000, 12'h654);
      apply(11'd147,  11'd205, 4'b0000, 12'h0F0, 11'd100, 11'd200, 12'h16F, 12'h96F);
      apply(11'd147,  11'd263, 4'b0000, 12'h111, 11'd100, 11'd200, 12'hFEF, 12'hFEF);
      apply(11'd100,  11'd264, 4'b0000, 12'h222, 11'd100, 11'd200, 12'h000, 12'h222);
      apply(11'd103,  11'd203, 4'b0000, 12'h8AC, 11'd100, 11'd200, 12'h0C3, 12'h8AC);
      apply(11'd110,  11'd205, 4'b1110, 12'h456, 11'd100, 11'd200, 12'h14A, 12'h000);
      apply(11'd110,  11'd205, 4'b0101, 12'h456, 11'd100, 11'd200, 12'h14A, 12'h000);
      // mid-frame position change must not move the sprite
      apply(11'd110,  11'd400, 4'b0000, 12'h333, 11'd300, 11'd200, 12'h000, 12'h333);
      apply(11'd110,  11'd205, 4'b0000, 12'h444, 11'd300, 11'd200, 12'h14A, 12'h94A);
      apply(11'd310,  11'd205, 4'b0000, 12'h777, 11'd300, 11'd200, 12'h000, 12'h777);
      // next frame: sprite moves to x=300
      apply(11'd0,    11'd0,   4'b0011, 12'h123, 11'd300, 11'd200, 12'h000, 12'h000);
      apply(11'd310,  11'd205, 4'b0000, 12'h555, 11'd300, 11'd200, 12'h14A, 12'h94A);
      apply(11'd110,  11'd205, 4'b0000, 12'h999, 11'd300, 11'd200, 12'h000, 12'h999);
      // right-edge clipping: xpos=1000, ypos=0
      apply(11'd0,    11'd0,   4'b0011, 12'h123, 11'd1000, 11'd0,  12'h000, 12'h000);
      apply(11'd1000, 11'd10,  4'b0000, 12'h101, 11'd1000, 11'd0,  12'h280, 12'hA80);
      apply(11'd1023, 11'd10,  4'b0000, 12'h202, 11'd1000, 11'd0,  12'h297, 12'hA97);
      apply(11'd0,    11'd10,  4'b0000, 12'hABC, 11'd1000, 11'd0,  12'h000, 12'hABC);
      apply(11'd5,    11'd10,  4'b0000, 12'hBCD, 11'd1000, 11'd0,  12'h000, 12'hBCD);
      apply(11'd23,   11'd10,  4'b0000, 12'hCDE, 11'd1000, 11'd0,  12'h000, 12'hCDE);
      apply(11'd1010, 11'd10,  4'b0000, 12'hDEF, 11'd1000, 11'd0,  12'h28A, 12'hA8A);

      // mid-line reset with pixels in flight: everything clears at once
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero();
      addr_q.delete();
      out_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      idle(4);
      // latch reverted to (0,0): sprite sits at the top-left corner
      apply(11'd10,   11'd10,  4'b0000, 12'h0AA, 11'd500, 11'd500, 12'h28A, 12'hA8A);
      apply(11'd48,   11'd10,  4'b0000, 12'h0BB, 11'd500, 11'd500, 12'h000, 12'h0BB);
      idle(1);

      // bounded drain of outstanding expectations
      for (int i = 0; i < 20 && (addr_q.size() > 0 || out_q.size() > 0); i++)
         @(negedge clk);
      if (addr_q.size() > 0 || out_q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d/%0d expectations left, expected 0", addr_q.size(), out_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
